// File: rtl/filter_scheduler.sv
// filter_scheduler: frame-synchronous controller for the threshold -> brightness
// -> ADSR filter chain. Debounces toggle keys, stages clamped BPM updates,
// derives a beat pulse from BPM with a per-frame phase accumulator and commits
// all configuration on frame_start only.
// Optional build macro FRAME_WATCHDOG_EN: forces a commit (no accumulator update,
// no beat) after WATCHDOG_CYCLES cycles without frame_start.
module filter_scheduler #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int FRAME_RATE      = 60,
    parameter int BPM_DEFAULT     = 80,
    parameter int BPM_MIN         = 30,
    parameter int BPM_MAX         = 240,
    parameter int WATCHDOG_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic [2:0] key_req,
    input  logic       auto_mode,
    input  logic [7:0] bpm_in,
    input  logic       bpm_valid,
    output logic [2:0] filter_enable,
    output logic [7:0] BPM_estimate,
    output logic       beat_pulse,
    output logic [2:0] pattern_idx
);
    localparam int NUM_KEYS = 3;
    localparam int CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [12:0]   THRESH  = 13'(60 * FRAME_RATE);

    typedef enum logic {RUN, COMMIT} state_t;

    state_t                         state;
    logic [NUM_KEYS-1:0][CW-1:0]    db_cnt;
    logic [NUM_KEYS-1:0]            db_fired;
    logic [NUM_KEYS-1:0]            accept;
    logic [2:0]                     pend_mask;
    logic [7:0]                     pend_bpm;
    logic [12:0]                    acc;
    logic [12:0]                    acc_next;
    logic                           wd_fire;

    // Per-key debouncer: one registered accept pulse per stable press; the
    // fired flag holds off further pulses until the key has been seen low.
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        always_ff @(posedge clk) begin
            if (reset) begin
                db_cnt[i]   <= '0;
                db_fired[i] <= 1'b0;
                accept[i]   <= 1'b0;
            end else begin
                accept[i] <= 1'b0;
                if (!key_req[i]) begin
                    db_cnt[i]   <= '0;
                    db_fired[i] <= 1'b0;
                end else if (!db_fired[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        accept[i]   <= 1'b1;
                        db_fired[i] <= 1'b1;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    // Pending mask: manual toggles XOR in, auto mode tracks gray(pattern_idx)
    // so switching back to manual keeps the last auto pattern.
    always_ff @(posedge clk) begin
        if (reset)
            pend_mask <= '0;
        else if (auto_mode)
            pend_mask <= pattern_idx ^ (pattern_idx >> 1);
        else
            pend_mask <= pend_mask ^ accept;
    end

    // Pending BPM: zero strobes ignored, others clamped; last strobe wins.
    always_ff @(posedge clk) begin
        if (reset)
            pend_bpm <= 8'(BPM_DEFAULT);
        else if (bpm_valid && (bpm_in != 8'd0)) begin
            if (bpm_in < 8'(BPM_MIN))
                pend_bpm <= 8'(BPM_MIN);
            else if (bpm_in > 8'(BPM_MAX))
                pend_bpm <= 8'(BPM_MAX);
            else
                pend_bpm <= bpm_in;
        end
    end

`ifdef FRAME_WATCHDOG_EN
    localparam int WW = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(WATCHDOG_CYCLES - 1);
    logic [WW-1:0] wd_cnt;

    assign wd_fire = !frame_start && (wd_cnt == WD_LAST);

    // Cycles since the last frame_start; restarts after each forced commit.
    always_ff @(posedge clk) begin
        if (reset || frame_start || (wd_cnt == WD_LAST))
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + 1'b1;
    end
`else
    logic unused_wd;
    assign unused_wd = (WATCHDOG_CYCLES == 0);
    assign wd_fire   = 1'b0;
`endif

    // Old committed BPM feeds the accumulator, as the new one lands this edge.
    assign acc_next = acc + {5'd0, BPM_estimate};

    // Commit FSM: frame_start is acted on at the edge that samples it, so the
    // registered outputs move one cycle after the pulse; COMMIT marks that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= RUN;
            filter_enable <= '0;
            BPM_estimate  <= 8'(BPM_DEFAULT);
            beat_pulse    <= 1'b0;
            pattern_idx   <= '0;
            acc           <= '0;
        end else begin
            beat_pulse <= 1'b0;
            state      <= RUN;
            if (frame_start) begin
                state         <= COMMIT;
                filter_enable <= pend_mask;
                BPM_estimate  <= pend_bpm;
                if (acc_next >= THRESH) begin
                    acc        <= acc_next - THRESH;
                    beat_pulse <= 1'b1;
                    if (auto_mode)
                        pattern_idx <= pattern_idx + 3'd1;
                end else begin
                    acc <= acc_next;
                end
            end else if (wd_fire) begin
                state         <= COMMIT;
                filter_enable <= pend_mask;
                BPM_estimate  <= pend_bpm;
            end
        end
    end

    logic unused_state;
    assign unused_state = (state == COMMIT);

endmodule

// File: doc/filter_scheduler.md
Name: filter_scheduler

Overview:
- Frame-synchronous controller for the threshold → brightness → ADSR filter chain.
- Owns each stage's filter_enable and the shared BPM_estimate.
- Debounces user toggle requests, clamps and stages BPM updates, and derives a beat pulse from BPM with a per-frame phase accumulator.
- Commits all configuration changes only on frame_start, so a frame is never rendered with mixed settings. In auto mode it steps an enable pattern on every beat.

Parameters:
DEBOUNCE_CYCLES, 250000, stable-high cycles before a key press is accepted (10 ms at 25 MHz)
FRAME_RATE, 60, frames per second; beat threshold = 60*FRAME_RATE
BPM_DEFAULT, 80, BPM after reset
BPM_MIN, 30, lower clamp for BPM
BPM_MAX, 240, upper clamp for BPM
WATCHDOG_CYCLES, 1000000, frame_start timeout (FRAME_WATCHDOG_EN only)

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high
frame_start  in  1  one-cycle pulse at hcount==0, vcount==0
key_req  in  3  raw active-high toggle requests: [0] thresh, [1] bright, [2] adsr
auto_mode  in  1  1 = beat-driven pattern, 0 = manual toggles
bpm_in  in  8  BPM from estimator
bpm_valid  in  1  bpm_in strobe
filter_enable  out  3  committed enables: [0] thresh, [1] bright, [2] adsr
BPM_estimate  out  8  committed BPM
beat_pulse  out  1  one-cycle pulse on each beat
pattern_idx  out  3  current auto-pattern index

Behaviour:
- One clock, clk. Reset is synchronous and active-high.
- Reset values:
  - filter_enable=0, BPM_estimate=BPM_DEFAULT, beat_pulse=0, pattern_idx=0.
  - Internal: accumulator=0, pending mask=0, pending BPM=BPM_DEFAULT, debouncers cleared.
  - Reset mid-frame discards all pending state.
- Debounce, per key:
  - Counter increments while the key is high and clears when it is low.
  - Reaching DEBOUNCE_CYCLES-1 fires a single accept pulse.
  - No further pulse until the key has been low for at least one cycle.
  - Holding a key gives exactly one toggle.
- Pending mask:
  - Manual mode: each accept pulse XORs its bit into the pending mask. Multiple keys in the same cycle all toggle.
  - Auto mode: accept pulses are ignored, and the pending mask = gray(pattern_idx) = {000,001,011,010,110,111,101,100} for idx 0..7.
- BPM staging:
  - bpm_valid with bpm_in==0 is ignored.
  - Otherwise pending BPM = clamp(bpm_in, BPM_MIN, BPM_MAX).
  - If several strobes arrive within one frame, the last one wins.
- FSM states:
  - RUN: default.
  - COMMIT: entered for one cycle on frame_start, then back to RUN.
- Actions in COMMIT, all registered, so outputs change 1 cycle after the frame_start pulse:
  - filter_enable ← pending mask.
  - BPM_estimate ← pending BPM.
  - acc_next = acc + BPM_estimate, using the old committed BPM. Accumulator width is 13 bits.
  - If acc_next ≥ 60*FRAME_RATE: acc ← acc_next − 60*FRAME_RATE, beat_pulse=1 for one cycle, and in auto mode pattern_idx increments (wrapping 7→0). Otherwise acc ← acc_next.
- Beat timing: the new pattern's mask reaches filter_enable at the next frame commit, one frame after the beat.
- Simultaneous events:
  - A key accept or bpm_valid in the same cycle as frame_start updates the pending state only. It is committed at the following frame.
  - frame_start while already in COMMIT (back-to-back pulses) is treated as a new commit on the next cycle.
- Mode switch:
  - Auto→manual: the pending mask keeps the last auto pattern.
  - Manual→auto: pattern_idx resumes from its held value.
- Beat period:
  - At most one beat per frame.
  - BPM ≤ BPM_MAX < 3600 guarantees the accumulator never exceeds 2× threshold.

Optional Feature:
FRAME_WATCHDOG_EN
- Defined:
  - A counter tracks clk cycles since the last frame_start.
  - On reaching WATCHDOG_CYCLES it forces a COMMIT with no accumulator update and no beat, then restarts.
  - Keeps configuration live when sync is absent (sim or VGA disabled).
- Undefined:
  - No counter is built.
  - Pending state waits indefinitely for frame_start.

Test Plan:
1. Reset → filter_enable=000, BPM_estimate=80, pattern_idx=0, beat_pulse=0.
2. DEBOUNCE_CYCLES=4, manual mode:
   - key_req[1] high 10 cycles → pending bit1 set once.
   - Next frame_start → filter_enable=010 one cycle later.
   - Key glitch of 2 cycles → no change.
3. bpm_in=255 strobe, then bpm_in=0 strobe, then frame_start → BPM_estimate=240. Before that frame_start, filter_enable and BPM_estimate are unchanged.
4. BPM committed at 120, FRAME_RATE=60, auto mode → beat_pulse every 30 frame_starts. pattern_idx 0→1→2, with filter_enable 000→001→011 one frame after each beat. Wrap 7→0 verified.
5. key accept coincident with frame_start → not committed that frame, committed at the next frame_start.
6. FRAME_WATCHDOG_EN, WATCHDOG_CYCLES=50, no frame_start, key toggle → filter_enable updates at cycle 50 with no beat_pulse. Without the macro, filter_enable stays 000.
